// File: rtl/cam_entry_dec_if.sv
// Command/row-control bundle between the CAM controller and cam_entry_dec.
// Optional build macro: CAM_ENTRY_DEC_ERR_EN adds the err_sticky status bit.
interface cam_entry_dec_if #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 4
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ENTRIES-1:0]  entry_we;
    logic                entry_set;
    logic [ENTRIES-1:0]  entry_valid;
    logic [ADDR_W:0]     valid_cnt;
    logic                full;
    logic                empty;
    logic                busy;
`ifdef CAM_ENTRY_DEC_ERR_EN
    logic                err_sticky;

    // Command issuer side
    modport master (
        output cmd_valid, cmd_op, cmd_addr,
        input  cmd_ready, entry_we, entry_set, entry_valid, valid_cnt,
               full, empty, busy, err_sticky
    );

    // Decoder side
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr,
        output cmd_ready, entry_we, entry_set, entry_valid, valid_cnt,
               full, empty, busy, err_sticky
    );
`else
    // Command issuer side
    modport master (
        output cmd_valid, cmd_op, cmd_addr,
        input  cmd_ready, entry_we, entry_set, entry_valid, valid_cnt,
               full, empty, busy
    );

    // Decoder side
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr,
        output cmd_ready, entry_we, entry_set, entry_valid, valid_cnt,
               full, empty, busy
    );
`endif
endinterface

// File: rtl/cam_entry_dec.sv
// CAM row decoder: binary row commands -> one-hot row write enables, plus the
// per-row valid mask, occupancy count and a one-row-per-cycle CLR_ALL sweep.
// Optional build macro: CAM_ENTRY_DEC_ERR_EN adds err_sticky (redundant SET,
// CLR of a dead row, or out-of-range row index; cleared by a completed sweep).
module cam_entry_dec #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cam_entry_dec_if.slave bus
);
    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(ENTRIES);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    typedef enum logic [1:0] {
        OP_SET     = 2'b00,
        OP_CLR     = 2'b01,
        OP_CLR_ALL = 2'b10,
        OP_NOP     = 2'b11
    } op_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ENTRIES-1:0]  we_q, we_d;
    logic                set_q, set_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic [ENTRIES-1:0]  cmd_onehot;
    logic [ENTRIES-1:0]  row_sel;
    logic                do_set;
    logic                row_was_valid;
`ifdef CAM_ENTRY_DEC_ERR_EN
    logic                err_q, err_d;
`endif

    // Next-state, row select and mask/count update
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        we_d          = '0;
        set_d         = 1'b0;
        valid_d       = valid_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        row_sel       = '0;
        do_set        = 1'b0;
        accept        = bus.cmd_valid && (state_q == IDLE);
        // Indices past the last row shift out and yield an all-zero select.
        cmd_onehot    = ENTRIES'(1'b1) << bus.cmd_addr;
`ifdef CAM_ENTRY_DEC_ERR_EN
        err_d         = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_SET: begin
                            row_sel = cmd_onehot;
                            do_set  = 1'b1;
                        end
                        OP_CLR: begin
                            row_sel = cmd_onehot;
                        end
                        OP_CLR_ALL: begin
                            // Row 0 is cleared on the accepting edge itself.
                            row_sel = ENTRIES'(1'b1);
                            state_d = SWEEP;
                            busy_d  = 1'b1;
                            idx_d   = ADDR_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
            SWEEP: begin
                row_sel = ENTRIES'(1'b1) << idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase

        row_was_valid = |(row_sel & valid_q);
        we_d          = row_sel;
        set_d         = do_set && (|row_sel);

        if (|row_sel) begin
            if (do_set) begin
                valid_d = valid_q | row_sel;
                if (!row_was_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d = valid_q & ~row_sel;
                if (row_was_valid) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end

`ifdef CAM_ENTRY_DEC_ERR_EN
        if (state_q == SWEEP && idx_q == LAST_IDX) begin
            err_d = 1'b0;
        end else if (accept) begin
            if (bus.cmd_op == OP_SET && (row_was_valid || !(|cmd_onehot))) begin
                err_d = 1'b1;
            end
            if (bus.cmd_op == OP_CLR && !row_was_valid) begin
                err_d = 1'b1;
            end
        end
`endif
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            we_q    <= '0;
            set_q   <= 1'b0;
            valid_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef CAM_ENTRY_DEC_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            set_q   <= set_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`ifdef CAM_ENTRY_DEC_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Ready and occupancy flags decode straight from registered state
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.entry_we    = we_q;
    assign bus.entry_set   = set_q;
    assign bus.entry_valid = valid_q;
    assign bus.valid_cnt   = cnt_q;
    assign bus.full        = (cnt_q == FULL_CNT);
    assign bus.empty       = (cnt_q == '0);
    assign bus.busy        = busy_q;
`ifdef CAM_ENTRY_DEC_ERR_EN
    assign bus.err_sticky  = err_q;
`endif

endmodule

// File: tb/tb_cam_entry_dec.sv
// Self-checking bench for cam_entry_dec (ENTRIES=16): vector table plus
// hand-built set-all, sweep and sweep-abort sequences, scoreboard queue.
module tb_cam_entry_dec;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned ADDR_W  = 4;

    localparam logic [1:0] SET     = 2'b00;
    localparam logic [1:0] CLR     = 2'b01;
    localparam logic [1:0] CLR_ALL = 2'b10;
    localparam logic [1:0] NOP     = 2'b11;

    typedef struct packed {
        logic        rst_n;
        logic        v;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] we;
        logic        set;
        logic [15:0] valid;
        logic [4:0]  cnt;
        logic        busy;
        logic        err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rec_no;
    vec_t exp_q[$];
    vec_t tbl[$];
    vec_t e;

    cam_entry_dec_if #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) bus ();

    cam_entry_dec #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input int addr, input logic [15:0] we, input logic set,
                                input logic [15:0] valid, input int cnt,
                                input logic busy, input logic err);
        vec_t t;
        t.rst_n = r;
        t.v     = v;
        t.op    = op;
        t.addr  = 4'(addr);
        t.we    = we;
        t.set   = set;
        t.valid = valid;
        t.cnt   = 5'(cnt);
        t.busy  = busy;
        t.err   = err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL rec%0d %s actual=%0h required=%0h", rec_no, name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus; the expected post-edge state is queued at the edge.
    task automatic drive(input vec_t t);
        rst_n         = t.rst_n;
        bus.cmd_valid = t.v;
        bus.cmd_op    = t.op;
        bus.cmd_addr  = t.addr;
        @(posedge clk);
        exp_q.push_back(t);
        #1;
    endtask

    // Scoreboard: compare outputs produced by the last edge against the queue head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("entry_we",    32'(bus.entry_we),    32'(e.we));
            if (e.we != 16'h0) chk("entry_set", 32'(bus.entry_set), 32'(e.set));
            chk("entry_valid", 32'(bus.entry_valid), 32'(e.valid));
            chk("valid_cnt",   32'(bus.valid_cnt),   32'(e.cnt));
            chk("busy",        32'(bus.busy),        32'(e.busy));
            chk("cmd_ready",   32'(bus.cmd_ready),   32'(!e.busy));
            chk("full",        32'(bus.full),        32'(e.cnt == 5'd16));
            chk("empty",       32'(bus.empty),       32'(e.cnt == 5'd0));
`ifdef CAM_ENTRY_DEC_ERR_EN
            chk("err_sticky",  32'(bus.err_sticky),  32'(e.err));
`endif
            rec_no++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        logic [15:0] oh;
        logic [15:0] low;
        checks        = 0;
        errors        = 0;
        rec_no        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_addr  = '0;
        @(posedge clk);
        #1;

        //         rst v  op       addr we        set valid     cnt busy err
        tbl.push_back(mk(0, 0, NOP,     0, 16'h0000, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, NOP,     0, 16'h0000, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, SET,     3, 16'h0008, 1, 16'h0008, 1, 0, 0));
        tbl.push_back(mk(1, 1, SET,    10, 16'h0400, 1, 16'h0408, 2, 0, 0));
        tbl.push_back(mk(1, 1, SET,    15, 16'h8000, 1, 16'h8408, 3, 0, 0));
        tbl.push_back(mk(1, 1, NOP,     6, 16'h0000, 0, 16'h8408, 3, 0, 0));
        tbl.push_back(mk(0, 1, SET,     1, 16'h0000, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, SET,     3, 16'h0008, 1, 16'h0008, 1, 0, 0));
        tbl.push_back(mk(1, 1, SET,     3, 16'h0008, 1, 16'h0008, 1, 0, 1));
        tbl.push_back(mk(1, 1, CLR,     5, 16'h0020, 0, 16'h0008, 1, 0, 1));
        tbl.push_back(mk(1, 1, CLR,     3, 16'h0008, 0, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(1, 0, SET,     7, 16'h0000, 0, 16'h0000, 0, 0, 1));
        foreach (tbl[i]) drive(tbl[i]);

        // Fill every row
        drive(mk(0, 0, NOP, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
        m = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            oh = 16'(1) << i;
            m  = m | oh;
            drive(mk(1, 1, SET, i, oh, 1, m, i + 1, 0, 0));
        end
        drive(mk(1, 0, NOP, 0, 16'h0000, 0, 16'hFFFF, 16, 0, 0));

        // Sweep from mask 0x00F0 with a SET 2 held pending throughout
        drive(mk(0, 0, NOP, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
        m = 16'h0000;
        for (int i = 4; i < 8; i++) begin
            oh = 16'(1) << i;
            m  = m | oh;
            drive(mk(1, 1, SET, i, oh, 1, m, i - 3, 0, 0));
        end
        drive(mk(1, 1, CLR_ALL, 9, 16'h0001, 0, 16'h00F0, 4, 1, 0));
        for (int i = 1; i < 16; i++) begin
            oh  = 16'(1) << i;
            low = 16'((32'd2 << i) - 32'd1);
            drive(mk(1, 1, SET, 2, oh, 0, m & ~low, $countones(m & ~low), i < 15, 0));
        end
        drive(mk(1, 1, SET, 2, 16'h0004, 1, 16'h0004, 1, 0, 0));

        // Sweep aborted by reset at step 6
        drive(mk(1, 1, SET, 9, 16'h0200, 1, 16'h0204, 2, 0, 0));
        drive(mk(1, 1, CLR_ALL, 0, 16'h0001, 0, 16'h0204, 2, 1, 0));
        drive(mk(1, 0, NOP, 0, 16'h0002, 0, 16'h0204, 2, 1, 0));
        drive(mk(1, 0, NOP, 0, 16'h0004, 0, 16'h0200, 1, 1, 0));
        drive(mk(1, 0, NOP, 0, 16'h0008, 0, 16'h0200, 1, 1, 0));
        drive(mk(1, 0, NOP, 0, 16'h0010, 0, 16'h0200, 1, 1, 0));
        drive(mk(1, 0, NOP, 0, 16'h0020, 0, 16'h0200, 1, 1, 0));
        drive(mk(0, 0, NOP, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
        drive(mk(1, 0, NOP, 0, 16'h0000, 0, 16'h0000, 0, 0, 0));
        drive(mk(1, 1, CLR, 4, 16'h0010, 0, 16'h0000, 0, 0, 1));

        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_entry_dec.md
Name: cam_entry_dec

Overview:
Decoder side of the CAM match path. It turns binary entry-index commands into one-hot per-entry write enables for the BRAM-backed CAM rows. It also owns the per-entry valid mask and occupancy count. A CLR_ALL sweep FSM invalidates every row, one per cycle, because BRAM rows cannot be cleared in parallel. Its entry_valid output is the mask the match logic ANDs with raw row hits before the 16:4 LSB-priority encode.

Parameters:
ENTRIES, 16, number of CAM rows; range 2..16.
ADDR_W, 4, index width; must equal clog2(ENTRIES).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  2  00 SET, 01 CLR, 10 CLR_ALL, 11 NOP
cmd_addr  input  ADDR_W  target row index; ignored for CLR_ALL and NOP
entry_we  output  ENTRIES  one-hot row write enable, registered
entry_set  output  1  qualifies entry_we: 1 = row being written valid, 0 = row being invalidated
entry_valid  output  ENTRIES  valid mask, bit i = row i holds live data
valid_cnt  output  ADDR_W+1  number of set bits in entry_valid
full  output  1  valid_cnt == ENTRIES
empty  output  1  valid_cnt == 0
busy  output  1  CLR_ALL sweep in progress

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, entry_we = 0, entry_set = 0, entry_valid = 0, valid_cnt = 0, busy = 0. Reset wins over any accepted command or sweep. A sweep is aborted, and the mask reads cleared anyway.
- States: IDLE and SWEEP. cmd_ready = (state == IDLE), combinational from state only. A command is accepted on the edge where cmd_valid && cmd_ready.
- SET accepted at edge k:
  - After edge k: entry_we = onehot(cmd_addr) for exactly one cycle, entry_set = 1.
  - entry_valid[cmd_addr] is set at the same edge (mask and we are visible in the same cycle).
  - valid_cnt increments only if the bit was previously 0. SET on a live row still pulses we (overwrite), with no count change.
- CLR accepted at edge k:
  - After edge k: entry_we = onehot(cmd_addr), entry_set = 0.
  - The bit is cleared at the same edge.
  - valid_cnt decrements only if the bit was previously 1. CLR on a dead row still pulses we.
- NOP: accepted; entry_we = 0 next cycle; no state change.
- cmd_addr >= ENTRIES (possible only when ENTRIES is not a power of 2): accepted; entry_we = 0, no mask or count change.
- CLR_ALL accepted at edge k:
  - State goes to SWEEP, busy = 1, internal sweep counter = 0.
  - After edge k+i (i = 0..ENTRIES-1): entry_we = onehot(i), entry_set = 0, bit i cleared, valid_cnt decremented if bit i was set.
  - At edge k+ENTRIES-1, state returns to IDLE and busy = 0 in the same cycle the last pulse is visible.
  - cmd_ready is low for ENTRIES-1 cycles. A new command is accepted at edge k+ENTRIES at the earliest.
  - At the end: entry_valid = 0, valid_cnt = 0.
- entry_we is all-zero in every cycle without an accepted SET/CLR or active sweep. It is never multi-hot.
- Back-to-back SET/CLR: one per cycle, no bubbles. Throughput is 1 command/cycle outside a sweep.
- full and empty are combinational decodes of the registered valid_cnt.
- Invariant, every cycle: valid_cnt == popcount(entry_valid).

Optional Feature:
CAM_ENTRY_DEC_ERR_EN
- Defined: adds output err_sticky (1 bit, reset 0). It sets and holds on any accepted SET to an already-valid row, CLR to an invalid row, or out-of-range cmd_addr. It is cleared only by reset or by completion of a CLR_ALL sweep. Datapath behaviour is identical to the undefined case.
- Undefined: port and logic are absent; these cases are silently handled as above.

Test Plan:
- Reset then idle -> entry_we = 0, entry_valid = 0, valid_cnt = 0, empty = 1, full = 0, cmd_ready = 1.
- SET 3, SET 10, SET 15 on consecutive cycles -> entry_we = 0x0008, 0x0400, 0x8000 on successive cycles, entry_set = 1; final entry_valid = 0x8408, valid_cnt = 3.
- SET 3 twice, then CLR 5 -> we pulses 0x0008, 0x0008, 0x0020; valid_cnt stays 1; with CAM_ENTRY_DEC_ERR_EN, err_sticky = 1 after the second SET.
- SET all 16 rows -> full = 1, valid_cnt = 16, entry_valid = 0xFFFF.
- From mask 0x00F0, CLR_ALL -> 16 consecutive one-hot pulses 0x0001..0x8000 with entry_set = 0; cmd_ready low for 15 cycles; valid_cnt goes 4 -> 0 as bits 4..7 clear; busy drops with the 0x8000 pulse; SET 2 held valid during the sweep is accepted immediately after.
- rst_n low at sweep step 6 -> next cycle entry_we = 0, entry_valid = 0, busy = 0, cmd_ready = 1.
